alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Command sequencer sitting in front of the accumulator ALU.
- Queues {mode, A, B, clear} commands from a requester through a valid/ready port and issues them to the ALU one at a time.
- Drives NoChange between issues so the accumulator holds its value.
- Captures each result and error code and returns them through a valid/ready response port; halts on any non-NoError result until software acknowledges.

Parameters:
- DATALEN, 8, operand/result width (matches ALU datalen)
- MODELEN, 4, function code width (matches ALU modelen)
- ERRORLEN, 2, error code width (matches ALU errorlen)
- FIFO_DEPTH, 4, command queue entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  queue can accept; equals !fifo_full
- cmd_mode  in  MODELEN  function code
- cmd_a  in  DATALEN  operand A
- cmd_b  in  DATALEN  operand B
- cmd_clear  in  1  drive ALU clear during this command's issue cycle
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  DATALEN  captured accumulator value
- rsp_err  out  ERRORLEN  captured ALU error code
- alu_mode  out  MODELEN  to ALU mode
- alu_inA  out  DATALEN  to ALU inA
- alu_inB  out  DATALEN  to ALU inB
- alu_clear  out  1  to ALU clear
- alu_out  in  DATALEN  ALU accumulator output
- alu_err  in  ERRORLEN  ALU error (combinational on mode)
- busy  out  1  state != IDLE or FIFO non-empty
- halted  out  1  state == HALT
- err_ack  in  1  leave HALT

Behaviour:
- Reset (async, active-high): state=IDLE; FIFO emptied; rsp_valid=0, rsp_data=0, rsp_err=00 (NoError); alu_mode=0000 (NoChange), alu_inA=alu_inB=0. alu_clear=1 while reset is high, so the accumulator zeroes on the next clk edge.
- FIFO: push on cmd_valid&&cmd_ready. Pop only in ISSUE. At full, cmd_ready=0 and the push is ignored. Wrap-around by pointer modulo FIFO_DEPTH. A push while popping is legal whenever not full.
- FSM states and actions:
  - IDLE: alu_mode=NoChange. Go to ISSUE if the FIFO is non-empty, else stay.
  - ISSUE (1 cycle): drive alu_mode/inA/inB/clear from the FIFO head; pop the head; register alu_err into err_q. Go to WAIT.
  - WAIT (1 cycle): alu_mode=NoChange, alu_clear=0. The accumulator was loaded at the ISSUE->WAIT edge. At the end of WAIT: rsp_data<=alu_out, rsp_err<=err_q, rsp_valid<=1. Go to RESP.
  - RESP: hold rsp_data/rsp_err stable while rsp_valid&&!rsp_ready. On handshake, rsp_valid<=0 and:
    - if rsp_err!=NoError, go to HALT;
    - else if the FIFO is non-empty, go to ISSUE (back-to-back, no IDLE bubble);
    - else go to IDLE.
  - HALT: alu_mode=NoChange; no issue; FIFO keeps accepting until full. err_ack=1 goes to IDLE and clears rsp_err to 00. err_ack in any other state is ignored.
- Latency: accept edge E0 -> ISSUE after E1 -> WAIT after E2 -> rsp_valid high after E3. Throughput: one command per 3 cycles with rsp_ready tied high.
- alu_clear=1 with a NoChange command yields result 0x00.
- Unknown mode codes are passed through unchanged; the sequencer does not decode modes.
- Outputs to the ALU are registered or decoded from state and FIFO head only; no combinational path from cmd_* to alu_*.

Decomposition:
- Shared package/header: mode codes (NoChange 0000, NOT 0001, ShiftLeft 0010, ShiftRight 0011, Load 0100, AND 0101, OR 0110, XOR 0111, Add 1000, Subtract 1001), error codes (NoError 00, Overflow 01, Underflow 10), FSM state encodings, width defaults.
- One sub-module, seq_cmd_fifo: parameterised sync FIFO with async reset, width MODELEN+2*DATALEN+1, outputs full/empty.

Test Plan:
1. Push Load A=0x51 at edge E0, rsp_ready=1 -> alu_mode=0100 for exactly one cycle; rsp_valid rises after E3; rsp_data=0x51, rsp_err=00.
2. Queue Load 0x55, OR B=0x58 (A=0x55), ShiftLeft back-to-back -> responses 0x55, 0x5D, 0xBA in order; ISSUE cycles spaced exactly 3 clocks apart.
3. rsp_ready=0 for 8 cycles with 5 commands offered -> rsp_data stable; 4 accepted, cmd_ready=0 on the 5th; release -> all responses in order, none lost.
4. ALU model returns alu_err=01 for Add -> rsp_err=01, then halted=1; a queued command is not issued (alu_mode stays 0000) until an err_ack pulse, then issues normally.
5. Command with cmd_clear=1, mode NoChange after accumulator=0xAB -> rsp_data=0x00.
6. Assert reset mid-WAIT -> immediate rsp_valid=0, cmd_ready=1, busy=0, alu_mode=0000, alu_clear=1; after release, Load 0x0F completes as in test 1.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared codes, FSM states and width defaults for the ALU command sequencer
package alu_sequencer_pkg;

  localparam int DATALEN_DEF    = 8;
  localparam int MODELEN_DEF    = 4;
  localparam int ERRORLEN_DEF   = 2;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [3:0] {
    MODE_NOCHANGE   = 4'b0000,
    MODE_NOT        = 4'b0001,
    MODE_SHIFTLEFT  = 4'b0010,
    MODE_SHIFTRIGHT = 4'b0011,
    MODE_LOAD       = 4'b0100,
    MODE_AND        = 4'b0101,
    MODE_OR         = 4'b0110,
    MODE_XOR        = 4'b0111,
    MODE_ADD        = 4'b1000,
    MODE_SUBTRACT   = 4'b1001
  } alu_mode_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_OVERFLOW  = 2'b01,
    ERR_UNDERFLOW = 2'b10
  } alu_err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_seq_cmd_fifo.sv
// rtl/alu_sequencer_seq_cmd_fifo.sv - synchronous command FIFO with async reset and full/empty flags
module seq_cmd_fifo
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 2 * DATALEN_DEF + MODELEN_DEF + 1,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - queues ALU commands, issues them one at a time and returns captured results
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATALEN    = DATALEN_DEF,
  parameter int MODELEN    = MODELEN_DEF,
  parameter int ERRORLEN   = ERRORLEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [MODELEN-1:0]  cmd_mode,
  input  logic [DATALEN-1:0]  cmd_a,
  input  logic [DATALEN-1:0]  cmd_b,
  input  logic                cmd_clear,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATALEN-1:0]  rsp_data,
  output logic [ERRORLEN-1:0] rsp_err,
  output logic [MODELEN-1:0]  alu_mode,
  output logic [DATALEN-1:0]  alu_inA,
  output logic [DATALEN-1:0]  alu_inB,
  output logic                alu_clear,
  input  logic [DATALEN-1:0]  alu_out,
  input  logic [ERRORLEN-1:0] alu_err,
  output logic                busy,
  output logic                halted,
  input  logic                err_ack
);

  localparam int CW = MODELEN + 2 * DATALEN + 1;

  seq_state_e          state_q, state_d;
  logic [MODELEN-1:0]  alu_mode_q, alu_mode_d;
  logic [DATALEN-1:0]  alu_ina_q, alu_ina_d;
  logic [DATALEN-1:0]  alu_inb_q, alu_inb_d;
  logic                alu_clear_q, alu_clear_d;
  logic [ERRORLEN-1:0] err_q, err_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATALEN-1:0]  rsp_data_q, rsp_data_d;
  logic [ERRORLEN-1:0] rsp_err_q, rsp_err_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_head;
  logic [MODELEN-1:0]  head_mode;
  logic [DATALEN-1:0]  head_a, head_b;
  logic                head_clear;

  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_pop   = (state_q == ST_ISSUE);
  assign head_mode  = fifo_head[CW-1 -: MODELEN];
  assign head_a     = fifo_head[2*DATALEN -: DATALEN];
  assign head_b     = fifo_head[DATALEN -: DATALEN];
  assign head_clear = fifo_head[0];

  seq_cmd_fifo #(
    .WIDTH(CW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata({cmd_mode, cmd_a, cmd_b, cmd_clear}),
    .pop  (fifo_pop),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    alu_mode_d  = MODELEN'(MODE_NOCHANGE);
    alu_ina_d   = '0;
    alu_inb_d   = '0;
    alu_clear_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        err_d   = alu_err;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        rsp_data_d  = alu_out;
        rsp_err_d   = err_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_err_q != ERRORLEN'(ERR_NONE)) state_d = ST_HALT;
          else if (!fifo_empty)                 state_d = ST_ISSUE;
          else                                  state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (err_ack) begin
          rsp_err_d = ERRORLEN'(ERR_NONE);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // ALU drives are registered, so load them from the head on the edge entering ISSUE.
    if (state_d == ST_ISSUE) begin
      alu_mode_d  = head_mode;
      alu_ina_d   = head_a;
      alu_inb_d   = head_b;
      alu_clear_d = head_clear;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      err_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
      alu_mode_q  <= '0;
      alu_ina_q   <= '0;
      alu_inb_q   <= '0;
      alu_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      alu_mode_q  <= alu_mode_d;
      alu_ina_q   <= alu_ina_d;
      alu_inb_q   <= alu_inb_d;
      alu_clear_q <= alu_clear_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_mode  = alu_mode_q;
  assign alu_inA   = alu_ina_q;
  assign alu_inB   = alu_inb_q;
  assign alu_clear = alu_clear_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer driving an accumulator ALU model
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_clear;
  logic [3:0] cmd_mode;
  logic [7:0] cmd_a, cmd_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic [3:0] alu_mode;
  logic [7:0] alu_inA, alu_inB, alu_out;
  logic       alu_clear;
  logic [1:0] alu_err;
  logic       busy, halted, err_ack;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_clear(cmd_clear),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_mode(alu_mode), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_clear(alu_clear),
    .alu_out(alu_out), .alu_err(alu_err),
    .busy(busy), .halted(halted), .err_ack(err_ack)
  );

  always #5 clk = ~clk;

  // Accumulator ALU the sequencer drives.
  logic [7:0] acc = 8'h00;
  assign alu_out = acc;
  always @(posedge clk) begin
    if (alu_clear) acc <= 8'h00;
    else case (alu_mode)
      4'd1: acc <= ~alu_inA;
      4'd2: acc <= acc << 1;
      4'd3: acc <= acc >> 1;
      4'd4: acc <= alu_inA;
      4'd5: acc <= alu_inA & alu_inB;
      4'd6: acc <= alu_inA | alu_inB;
      4'd7: acc <= alu_inA ^ alu_inB;
      4'd8: acc <= alu_inA + alu_inB;
      4'd9: acc <= alu_inA - alu_inB;
      default: acc <= acc;
    endcase
  end
  always_comb begin
    alu_err = 2'b00;
    if (alu_mode == 4'd8 && ({1'b0, alu_inA} + {1'b0, alu_inB}) > 9'd255) alu_err = 2'b01;
    if (alu_mode == 4'd9 && alu_inA < alu_inB) alu_err = 2'b10;
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
  } rsp_t;

  rsp_t       exp_q[$];
  int         issue_cyc[$];
  int         ref_acc = 0;
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;
  bit         auto_mode = 0;
  logic [7:0] last_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: each accepted command's result follows from plain integer arithmetic in order.
  task automatic model_push(input int m, input int a, input int b, input bit clr);
    int r;
    int e;
    r = ref_acc;
    e = 0;
    case (m)
      1: r = 255 - a;
      2: r = (ref_acc * 2) % 256;
      3: r = ref_acc / 2;
      4: r = a;
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: begin r = (a + b) % 256; if (a + b > 255) e = 1; end
      9: begin r = (a - b + 256) % 256; if (a < b) e = 2; end
      default: r = ref_acc;
    endcase
    if (clr) r = 0;
    ref_acc = r;
    exp_q.push_back('{data: r[7:0], err: e[1:0]});
  endtask

  // Monitor: pops the scoreboard on each response handshake and checks hold/halt rules.
  bit          prev_stall = 0;
  logic [10:0] prev_word = '0;
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) check("stall_hold", {21'd0, rsp_valid, rsp_err, rsp_data}, {21'd0, prev_word});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
          check("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
          last_data = rsp_data;
        end
      end
      if (halted) check("halt_nochange", {28'd0, alu_mode}, 32'd0);
      if (alu_mode != 4'd0) issue_cyc.push_back(cyc);
      prev_stall = rsp_valid && !rsp_ready;
      prev_word  = {rsp_valid, rsp_err, rsp_data};
    end
  end

  task automatic tick();
    @(negedge clk);
    if (auto_mode) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      err_ack   = halted && ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic try_push(input int m, input int a, input int b, input bit clr,
                          input int budget, output bit ok);
    cmd_mode  = 4'(m);
    cmd_a     = 8'(a);
    cmd_b     = 8'(b);
    cmd_clear = clr;
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (cmd_ready) begin
        model_push(m, a, b, clr);
        ok = 1;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push(input int m, input int a, input int b, input bit clr);
    bit ok;
    try_push(m, a, b, clr, 300, ok);
    check("push_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    auto_mode = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!busy && !rsp_valid && exp_q.size() == 0) break;
      err_ack = halted;
      tick();
    end
    err_ack = 1'b0;
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n_acc;
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_a = '0; cmd_b = '0; cmd_clear = 1'b0;
    rsp_ready = 1'b1; err_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_alu_mode", {28'd0, alu_mode}, 32'd0);
    check("rst_alu_clear", {31'd0, alu_clear}, 32'd1);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    ref_acc = 0;
    tick();

    // Single Load: exact latency and one-cycle issue.
    issue_cyc.delete();
    push(4, 'h51, 0, 0);
    tick();
    check("t1_issue_mode", {28'd0, alu_mode}, 32'd4);
    check("t1_issue_inA", {24'd0, alu_inA}, 32'h51);
    check("t1_early_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("t1_wait_mode", {28'd0, alu_mode}, 32'd0);
    check("t1_wait_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t1_rsp_data", {24'd0, rsp_data}, 32'h51);
    drain();
    check("t1_issue_count", issue_cyc.size(), 32'd1);

    // Back-to-back: three commands, issues three clocks apart.
    issue_cyc.delete();
    push(4, 'h55, 0, 0);
    push(6, 'h55, 'h58, 0);
    push(2, 0, 0, 0);
    drain();
    check("t2_issue_count", issue_cyc.size(), 32'd3);
    if (issue_cyc.size() == 3) begin
      check("t2_gap0", issue_cyc[1] - issue_cyc[0], 32'd3);
      check("t2_gap1", issue_cyc[2] - issue_cyc[1], 32'd3);
    end
    check("t2_last", {24'd0, last_data}, 32'hBA);

    // Stalled consumer: FIFO fills to depth, fifth command refused.
    rsp_ready = 1'b0;
    push(4, 'h11, 0, 0);
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    check("t3_rsp_wait", {31'd0, rsp_valid}, 32'd1);
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
      try_push(5 + (k % 3), $urandom_range(0, 255), $urandom_range(0, 255), 0, 1, ok);
      n_acc += int'(ok);
    end
    check("t3_accepted", n_acc, 32'd4);
    repeat (3) tick();
    drain();

    // Overflow halts the sequencer until err_ack.
    push(4, 'hF0, 0, 0);
    push(8, 'hF0, 'h20, 0);
    for (int i = 0; i < 20 && !halted; i++) tick();
    check("t4_halted", {31'd0, halted}, 32'd1);
    check("t4_rsp_err", {30'd0, rsp_err}, 32'd1);
    push(4, 'h33, 0, 0);
    repeat (5) begin
      tick();
      check("t4_no_issue", {28'd0, alu_mode}, 32'd0);
    end
    err_ack = 1'b1;
    tick();
    err_ack = 1'b0;
    check("t4_unhalted", {31'd0, halted}, 32'd0);
    check("t4_err_cleared", {30'd0, rsp_err}, 32'd0);
    drain();
    check("t4_last", {24'd0, last_data}, 32'h33);

    // Clear with NoChange zeroes the accumulator.
    push(4, 'hAB, 0, 0);
    push(0, 0, 0, 1);
    drain();
    check("t5_clear", {24'd0, last_data}, 32'h00);

    // Reset during WAIT.
    push(4, 'h77, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_alu_mode", {28'd0, alu_mode}, 32'd0);
    check("t6_alu_clear", {31'd0, alu_clear}, 32'd1);
    exp_q.delete();
    ref_acc = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    push(4, 'h0F, 0, 0);
    tick();
    tick();
    tick();
    check("t6_rsp_valid_after", {31'd0, rsp_valid}, 32'd1);
    check("t6_rsp_data_after", {24'd0, rsp_data}, 32'h0F);
    drain();

    // Random traffic with random backpressure and acknowledges.
    auto_mode = 1;
    repeat (60) begin
      int m;
      m = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      push(m, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
